tank_access_scheduler: RTL and testbench

Sequences the single water tank between its consumers: refill, sprinkler, dripper and fertiliser dosing with post-dose cleaning. It sits between the switch/button conditioning logic and the valve/display outputs of the irrigation top level. It grants at most one consumer at a time, enforces refill priority at critical level and a minimum dwell per irrigation grant. It also rotates fairly between sprinkler and dripper.

---
 rtl/tank_access_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_tank_access_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tank_access_scheduler.sv
// Water tank access scheduler: grants the single tank to one consumer at a
// time (refill, sprinkler, dripper, fertiliser dose, line cleaning), with
// refill priority at critical level, a minimum irrigation dwell and
// round-robin fairness between sprinkler and dripper.
module tank_access_scheduler #(
  parameter int DWELL_TICKS    = 4,
  parameter int CLEAN_TICKS    = 3,
  parameter int CRITICAL_LEVEL = 1,
  parameter int FULL_LEVEL     = 7
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic [2:0] water_level_i,
  input  logic       input_error_i,
  input  logic       splinker_request_i,
  input  logic       dripper_request_i,
  input  logic       fertilise_request_i,
  output logic       filling_o,
  output logic       splinker_o,
  output logic       dripper_o,
  output logic       fertilising_o,
  output logic       cleaning_o,
  output logic [2:0] state_o
);

  // Counter is shared between irrigation dwell and cleaning duration.
  localparam int CNT_MAX_TICKS = (DWELL_TICKS > CLEAN_TICKS) ? DWELL_TICKS : CLEAN_TICKS;
  localparam int CNT_W         = $clog2(CNT_MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] DWELL_CNT  = CNT_W'(DWELL_TICKS);
  localparam logic [CNT_W-1:0] CLEAN_LAST = CNT_W'(CLEAN_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [2:0]       CRIT_LVL   = 3'(CRITICAL_LEVEL);
  localparam logic [2:0]       FULL_LVL   = 3'(FULL_LEVEL);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_FILL      = 3'b001,
    ST_SPRINKLE  = 3'b010,
    ST_DRIP      = 3'b011,
    ST_FERTILISE = 3'b100,
    ST_CLEAN     = 3'b101,
    ST_ERROR     = 3'b110
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rr_q;          // 0: sprinkler preferred, 1: dripper preferred
  logic             fert_pend_q;
  logic             filling_q, splinker_q, dripper_q, fertilising_q, cleaning_q;

  logic critical_s;
  logic dwell_met_s;
  logic clean_done_s;
  logic counting_s;
  logic state_change_s;
  logic irrig_state_s;

  assign critical_s     = (water_level_i <= CRIT_LVL);
  assign dwell_met_s    = (cnt_q >= DWELL_CNT);
  // The third tick after entry ends cleaning on that same edge.
  assign clean_done_s   = tick_i && (cnt_q >= CLEAN_LAST);
  assign counting_s     = (state_q == ST_SPRINKLE) || (state_q == ST_DRIP) || (state_q == ST_CLEAN);
  assign irrig_state_s  = (state_q == ST_SPRINKLE) || (state_q == ST_DRIP);
  assign state_change_s = (state_d != state_q);

  // Next-state selection following the per-state priority rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (input_error_i) begin
          state_d = ST_ERROR;
        end else if (critical_s) begin
          state_d = ST_FILL;
        end else if (fert_pend_q) begin
          state_d = ST_FERTILISE;
        end else if (splinker_request_i && dripper_request_i) begin
          state_d = rr_q ? ST_DRIP : ST_SPRINKLE;
        end else if (splinker_request_i) begin
          state_d = ST_SPRINKLE;
        end else if (dripper_request_i) begin
          state_d = ST_DRIP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (water_level_i == FULL_LVL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_SPRINKLE: begin
        if (input_error_i) begin
          state_d = ST_ERROR;
        end else if (critical_s) begin
          state_d = ST_FILL;
        end else if (!splinker_request_i) begin
          state_d = ST_IDLE;
        end else if (dwell_met_s && dripper_request_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SPRINKLE;
        end
      end
      ST_DRIP: begin
        if (input_error_i) begin
          state_d = ST_ERROR;
        end else if (critical_s) begin
          state_d = ST_FILL;
        end else if (!dripper_request_i) begin
          state_d = ST_IDLE;
        end else if (dwell_met_s && splinker_request_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRIP;
        end
      end
      ST_FERTILISE: begin
        if (input_error_i) begin
          state_d = ST_ERROR;
        end else if (critical_s) begin
          state_d = ST_CLEAN;
        end else begin
          state_d = ST_FERTILISE;
        end
      end
      ST_CLEAN: begin
        if (clean_done_s) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_CLEAN;
        end
      end
      ST_ERROR: begin
        if (!input_error_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, fairness pointer, pending flag and registered grants.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rr_q          <= 1'b0;
      fert_pend_q   <= 1'b0;
      filling_q     <= 1'b0;
      splinker_q    <= 1'b0;
      dripper_q     <= 1'b0;
      fertilising_q <= 1'b0;
      cleaning_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      filling_q     <= (state_d == ST_FILL);
      splinker_q    <= (state_d == ST_SPRINKLE);
      dripper_q     <= (state_d == ST_DRIP);
      fertilising_q <= (state_d == ST_FERTILISE);
      cleaning_q    <= (state_d == ST_CLEAN);

      // Clear on any state change takes precedence over a coincident tick.
      if (state_change_s) begin
        cnt_q <= '0;
      end else if (tick_i && counting_s && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end

      // Any end of an irrigation grant hands preference to the other side.
      if (irrig_state_s && state_change_s) begin
        rr_q <= ~rr_q;
      end else begin
        rr_q <= rr_q;
      end

      // Dose requests arriving while dosing or cleaning are dropped.
      if ((state_d == ST_FERTILISE) && (state_q != ST_FERTILISE)) begin
        fert_pend_q <= 1'b0;
      end else if (fertilise_request_i && (state_q != ST_FERTILISE) && (state_q != ST_CLEAN)) begin
        fert_pend_q <= 1'b1;
      end else begin
        fert_pend_q <= fert_pend_q;
      end
    end
  end

  assign filling_o     = filling_q;
  assign splinker_o    = splinker_q;
  assign dripper_o     = dripper_q;
  assign fertilising_o = fertilising_q;
  assign cleaning_o    = cleaning_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_tank_access_scheduler.sv
// Directed self-checking bench for tank_access_scheduler. Each observation
// packs {state, filling, splinker, dripper, fertilising, cleaning} into 8 bits
// and compares it with a hand-written expected word.
module tb_tank_access_scheduler;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       tick_i = 1'b0;
  logic [2:0] water_level_i = 3'd5;
  logic       input_error_i = 1'b0;
  logic       splinker_request_i = 1'b0;
  logic       dripper_request_i = 1'b0;
  logic       fertilise_request_i = 1'b0;
  logic       filling_o, splinker_o, dripper_o, fertilising_o, cleaning_o;
  logic [2:0] state_o;

  int checks_q = 0;
  int errors_q = 0;

  // Expected observation words: {state[2:0], fill, spr, drp, fert, clean}
  localparam logic [7:0] W_IDLE = 8'b000_00000;
  localparam logic [7:0] W_FILL = 8'b001_10000;
  localparam logic [7:0] W_SPR  = 8'b010_01000;
  localparam logic [7:0] W_DRP  = 8'b011_00100;
  localparam logic [7:0] W_FRT  = 8'b100_00010;
  localparam logic [7:0] W_CLN  = 8'b101_00001;
  localparam logic [7:0] W_ERR  = 8'b110_00000;

  tank_access_scheduler dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .tick_i              (tick_i),
    .water_level_i       (water_level_i),
    .input_error_i       (input_error_i),
    .splinker_request_i  (splinker_request_i),
    .dripper_request_i   (dripper_request_i),
    .fertilise_request_i (fertilise_request_i),
    .filling_o           (filling_o),
    .splinker_o          (splinker_o),
    .dripper_o           (dripper_o),
    .fertilising_o       (fertilising_o),
    .cleaning_o          (cleaning_o),
    .state_o             (state_o)
  );

  // Free-running 10 ns clock.
  always #5 clock_i = ~clock_i;

  function automatic logic [7:0] obs_s();
    return {state_o, filling_o, splinker_o, dripper_o, fertilising_o, cleaning_o};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One active edge, then settle on the following falling edge.
  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  // One cycle carrying a tick pulse.
  task automatic tick_step();
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
  endtask

  initial begin
    // Reset held with a pending sprinkler request.
    splinker_request_i = 1'b1;
    water_level_i      = 3'd5;
    step();
    step();
    check_eq("reset_idle", obs_s(), W_IDLE);
    reset_i = 1'b0;
    step();
    check_eq("post_reset_spr", obs_s(), W_SPR);

    // Both requests: dwell of 4 ticks, one IDLE cycle, then rotate.
    dripper_request_i = 1'b1;
    tick_step();
    tick_step();
    step();
    step();
    check_eq("dwell_not_met_hold", obs_s(), W_SPR);
    tick_step();
    tick_step();
    check_eq("spr_after_4_ticks", obs_s(), W_SPR);
    step();
    check_eq("gap_idle_1", obs_s(), W_IDLE);
    step();
    check_eq("rr_to_drip", obs_s(), W_DRP);
    for (int i = 0; i < 4; i++) tick_step();
    check_eq("drp_after_4_ticks", obs_s(), W_DRP);
    step();
    check_eq("gap_idle_2", obs_s(), W_IDLE);
    step();
    check_eq("rr_back_spr", obs_s(), W_SPR);

    // Critical level pre-empts the sprinkler; refill ignores errors.
    dripper_request_i = 1'b0;
    water_level_i     = 3'd2;
    step();
    check_eq("level2_not_critical", obs_s(), W_SPR);
    water_level_i = 3'd1;
    step();
    check_eq("critical_fill", obs_s(), W_FILL);
    input_error_i = 1'b1;
    water_level_i = 3'd4;
    step();
    check_eq("fill_ignores_error", obs_s(), W_FILL);
    input_error_i = 1'b0;
    water_level_i = 3'd7;
    step();
    check_eq("fill_done_idle", obs_s(), W_IDLE);
    step();
    check_eq("spr_regrant", obs_s(), W_SPR);

    // Fertiliser pulse during dripper waits for the dripper to finish.
    splinker_request_i = 1'b0;
    water_level_i      = 3'd5;
    step();
    check_eq("spr_release_idle", obs_s(), W_IDLE);
    dripper_request_i = 1'b1;
    step();
    check_eq("drp_grant", obs_s(), W_DRP);
    fertilise_request_i = 1'b1;
    step();
    fertilise_request_i = 1'b0;
    step();
    check_eq("drp_continues", obs_s(), W_DRP);
    dripper_request_i = 1'b0;
    step();
    check_eq("drp_release_idle", obs_s(), W_IDLE);
    step();
    check_eq("fert_grant", obs_s(), W_FRT);
    water_level_i = 3'd3;
    step();
    check_eq("fert_hold", obs_s(), W_FRT);
    // Entry edge carries a tick that must not count toward cleaning.
    water_level_i = 3'd1;
    tick_step();
    check_eq("clean_entry", obs_s(), W_CLN);
    fertilise_request_i = 1'b1;
    input_error_i       = 1'b1;
    step();
    fertilise_request_i = 1'b0;
    check_eq("clean_ignores_error", obs_s(), W_CLN);
    tick_step();
    check_eq("clean_tick1", obs_s(), W_CLN);
    tick_step();
    step();
    check_eq("clean_tick2", obs_s(), W_CLN);
    tick_step();
    check_eq("clean_to_fill", obs_s(), W_FILL);
    step();
    check_eq("fill_after_clean_err", obs_s(), W_FILL);
    input_error_i = 1'b0;
    water_level_i = 3'd7;
    step();
    check_eq("fill2_done", obs_s(), W_IDLE);
    step();
    check_eq("clean_req_dropped", obs_s(), W_IDLE);

    // Error during dosing; pending flag stays consumed afterwards.
    water_level_i       = 3'd5;
    fertilise_request_i = 1'b1;
    step();
    fertilise_request_i = 1'b0;
    check_eq("fert_pend_idle", obs_s(), W_IDLE);
    step();
    check_eq("fert_grant2", obs_s(), W_FRT);
    input_error_i = 1'b1;
    step();
    check_eq("fert_to_error", obs_s(), W_ERR);
    step();
    check_eq("error_hold", obs_s(), W_ERR);
    input_error_i = 1'b0;
    step();
    check_eq("error_clear_idle", obs_s(), W_IDLE);
    step();
    check_eq("no_rearm", obs_s(), W_IDLE);

    // Error outranks critical level in IDLE.
    water_level_i = 3'd0;
    input_error_i = 1'b1;
    step();
    check_eq("idle_err_over_crit", obs_s(), W_ERR);
    input_error_i = 1'b0;
    step();
    check_eq("err_exit_idle", obs_s(), W_IDLE);
    step();
    check_eq("idle_crit_fill", obs_s(), W_FILL);

    // Asynchronous reset drops the refill grant without an edge.
    #2 reset_i = 1'b1;
    #1 check_eq("async_reset", obs_s(), W_IDLE);
    step();
    check_eq("reset_held", obs_s(), W_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
